// File: rtl/fifo_drain_ctrl.sv
// ----------------------------------------------------------------------------
// fifo_drain_ctrl
//
// Drains words from a source FIFO (one-cycle read latency) into a downstream
// FIFO. Pops are issued against a two-word credit: words in flight plus words
// parked in a 2-entry hold buffer may never exceed two. A downstream
// back-pressure flag parks words in the hold buffer. Pushes are registered.
// Word order is preserved.
//
// Optional feature: define XFER_CNT_EN to add the 8-bit xfer_count output.
// This output counts dest_push cycles and wraps from 255 to 0.
// With XFER_CNT_EN undefined, the port and its counter are absent.
//
// Ports
//   clk               in   system clock, all state on rising edge
//   reset             in   asynchronous active-low reset
//   enable            in   permits new pops from the source FIFO
//   fifo_empty        in   source FIFO holds no words
//   fifo_almost_empty in   source FIFO holds <=1 word (status only)
//   fifo_data   [9:0] in   source read data, valid the cycle after fifo_pop
//   fifo_pop          out  pop strobe to the source FIFO (combinational)
//   dest_almost_full  in   downstream FIFO cannot accept further pushes
//   dest_push         out  registered push strobe to the downstream FIFO
//   dest_data   [9:0] out  registered word accompanying dest_push
//   busy              out  high whenever state != IDLE
//   state       [1:0] out  00 IDLE, 01 RUN, 10 STALL
//   xfer_count  [7:0] out  words pushed downstream (XFER_CNT_EN only)
// ----------------------------------------------------------------------------
module fifo_drain_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic       fifo_almost_empty,
  input  logic [9:0] fifo_data,
  output logic       fifo_pop,
  input  logic       dest_almost_full,
  output logic       dest_push,
  output logic [9:0] dest_data,
  output logic       busy,
  output logic [1:0] state
`ifdef XFER_CNT_EN
  ,
  output logic [7:0] xfer_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STALL = 2'b10
  } state_t;

  state_t     r_state;
  state_t     w_state_next;

  logic       r_rst_done;   // set by the first rising edge seen out of reset
  logic       r_inflight;   // a word requested last cycle is on fifo_data now
  logic [1:0] r_buf_cnt;
  logic [9:0] r_buf [2];    // hold buffer, entry 0 is the oldest word
  logic       r_dest_push;
  logic [9:0] r_dest_data;

  logic       w_credit_ok;
  logic       w_pop;
  logic       w_drain;
  logic       w_direct;
  logic       w_store;
  logic       w_load;
  logic [9:0] w_load_data;
  logic [1:0] w_cnt_after;
  logic [1:0] w_buf_cnt_next;
  logic [9:0] w_buf_next [2];

  // The almost-empty flag is informational only and deliberately has no
  // effect on popping.
  logic       w_unused;
  assign w_unused = fifo_almost_empty;

  // Credit: at most two words may be owed to the output (buffered + in flight),
  // which is what keeps the hold buffer from ever overflowing.
  assign w_credit_ok = ({1'b0, r_buf_cnt} + {2'b00, r_inflight}) < 3'd2;

  // r_rst_done is cleared asynchronously, so this also holds pop low during
  // reset and for the cycle in which reset is released.
  assign w_pop = r_rst_done & enable & ~fifo_empty & w_credit_ok;

  // The buffer head always wins the output register; a word captured in the
  // same cycle then goes into the buffer behind it.
  assign w_drain     = ~dest_almost_full & (r_buf_cnt != 2'd0);
  assign w_direct    = ~dest_almost_full & (r_buf_cnt == 2'd0) & r_inflight;
  assign w_store     = r_inflight & ~w_direct;
  assign w_load      = w_drain | w_direct;
  assign w_load_data = w_drain ? r_buf[0] : fifo_data;

  always_comb begin
    w_buf_next[0]  = r_buf[0];
    w_buf_next[1]  = r_buf[1];
    w_cnt_after    = r_buf_cnt - {1'b0, w_drain};
    if (w_drain) begin
      w_buf_next[0] = r_buf[1];
    end
    // The credit rule guarantees w_cnt_after is 0 or 1 whenever a word is stored.
    if (w_store) begin
      if (w_cnt_after == 2'd0) begin
        w_buf_next[0] = fifo_data;
      end else begin
        w_buf_next[1] = fifo_data;
      end
    end
    w_buf_cnt_next = w_cnt_after + {1'b0, w_store};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rst_done  <= 1'b0;
      r_inflight  <= 1'b0;
      r_buf_cnt   <= 2'd0;
      r_buf[0]    <= 10'd0;
      r_buf[1]    <= 10'd0;
      r_dest_push <= 1'b0;
      r_dest_data <= 10'd0;
    end else begin
      r_rst_done  <= 1'b1;
      r_inflight  <= w_pop;
      r_buf_cnt   <= w_buf_cnt_next;
      r_buf[0]    <= w_buf_next[0];
      r_buf[1]    <= w_buf_next[1];
      r_dest_push <= w_load;
      if (w_load) begin
        r_dest_data <= w_load_data;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_pop) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (dest_almost_full && (r_buf_cnt != 2'd0)) begin
          w_state_next = ST_STALL;
        end else if ((r_buf_cnt == 2'd0) && !r_inflight && !w_pop) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_STALL: begin
        if (!dest_almost_full) begin
          w_state_next = ST_RUN;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    fifo_pop  = w_pop;
    dest_push = r_dest_push;
    dest_data = r_dest_data;
    busy      = (r_state != ST_IDLE);
    state     = r_state;
  end

`ifdef XFER_CNT_EN
  logic [7:0] r_xfer_count;

  // Counts at the edge that raises dest_push, so the count already includes
  // the word currently being presented.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_xfer_count <= 8'd0;
    end else if (w_load) begin
      r_xfer_count <= r_xfer_count + 8'd1;
    end
  end

  assign xfer_count = r_xfer_count;
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
module tb_fifo_drain_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       fifo_empty;
  logic       fifo_almost_empty;
  logic [9:0] fifo_data;
  logic       fifo_pop;
  logic       dest_almost_full;
  logic       dest_push;
  logic [9:0] dest_data;
  logic       busy;
  logic [1:0] state;
`ifdef XFER_CNT_EN
  logic [7:0] xfer_count;
`endif

  always #5 clk = ~clk;

  fifo_drain_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .enable            (enable),
    .fifo_empty        (fifo_empty),
    .fifo_almost_empty (fifo_almost_empty),
    .fifo_data         (fifo_data),
    .fifo_pop          (fifo_pop),
    .dest_almost_full  (dest_almost_full),
    .dest_push         (dest_push),
    .dest_data         (dest_data),
    .busy              (busy),
    .state             (state)
`ifdef XFER_CNT_EN
    ,
    .xfer_count        (xfer_count)
`endif
  );

  typedef struct {
    bit         rst_n;
    bit         en;
    bit         empty;
    bit         daf;
    logic [9:0] data;
    bit         exp_pop;
    bit         exp_push;
    logic [9:0] exp_data;
    logic [1:0] exp_state;
  } vec_t;

  vec_t tbl [14];

  int n_vec = 0;
  int n_err = 0;

  // Reference model: source FIFO contents, words owed downstream, and counts.
  logic [9:0] src_q [$];
  logic [9:0] exp_q [$];
  int         push_cyc [$];
  int         n_popped;
  int         n_pushed;
  int         n_xfer;
  int         cyc = 0;
  int         first_pop_cyc;
  bit         edge_ok;
  bit         exp_push_next;

  function automatic vec_t mk(bit r, bit e, bit m, bit f, logic [9:0] d,
                              bit p, bit q, logic [9:0] xd, logic [1:0] s);
    vec_t v;
    v.rst_n = r; v.en = e; v.empty = m; v.daf = f; v.data = d;
    v.exp_pop = p; v.exp_push = q; v.exp_data = xd; v.exp_state = s;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic src_update();
    fifo_empty        = (src_q.size() == 0);
    fifo_almost_empty = (src_q.size() <= 1);
  endtask

  // One clock period, entered and left at posedge+1. Words owed downstream are
  // those popped in earlier cycles and not yet pushed; a push is due the cycle
  // after any cycle with words owed and no back-pressure.
  task automatic cycle();
    int         avail;
    bit         pop_seen;
    logic [9:0] w;
    @(negedge clk);
    check("dest_push", 32'(dest_push), 32'(exp_push_next));
    if (dest_push) begin
      n_pushed++;
      n_xfer++;
      push_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL dest_data: pushed 0x%0h, expected no word", dest_data);
      end else begin
        check("dest_data", 32'(dest_data), 32'(exp_q.pop_front()));
      end
    end
    avail = n_popped - n_pushed;
    check("fifo_pop", 32'(fifo_pop),
          32'(edge_ok && enable && !fifo_empty && (avail < 2)));
    if (avail > 0) check("busy_owed", 32'(busy), 32'd1);
    if (fifo_pop && first_pop_cyc < 0) first_pop_cyc = cyc;
    exp_push_next = !dest_almost_full && (avail > 0);
    pop_seen = fifo_pop;
    @(posedge clk);
    cyc++;
    if (reset) edge_ok = 1'b1;
    #1;
    if (pop_seen) begin
      n_popped++;
      if (src_q.size() > 0) begin
        w = src_q.pop_front();
        exp_q.push_back(w);
        fifo_data = w;
      end else begin
        fifo_data = 10'($urandom);
      end
    end else begin
      fifo_data = 10'($urandom);
    end
    src_update();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_push", 32'(dest_push), 32'd0);
    check("rst_data", 32'(dest_data), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pop", 32'(fifo_pop), 32'd0);
`ifdef XFER_CNT_EN
    check("rst_xfer", 32'(xfer_count), 32'd0);
`endif
    @(posedge clk);
    #1;
    check("rst_push_hold", 32'(dest_push), 32'd0);
    reset = 1'b1;
    edge_ok = 1'b0;
    n_popped = 0;
    n_pushed = 0;
    n_xfer = 0;
    exp_q.delete();
    push_cyc.delete();
    first_pop_cyc = -1;
    exp_push_next = 1'b0;
    fifo_data = 10'($urandom);
    src_update();
  endtask

  task automatic drain(input int max_cyc);
    int k = 0;
    while (!(n_popped == n_pushed && !exp_push_next && (!enable || src_q.size() == 0))
           && k < max_cyc) begin
      cycle();
      k++;
    end
    if (k >= max_cyc) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: still transferring after %0d cycles, expected idle", max_cyc);
    end
    check("idle_state", 32'(state), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; enable = 1'b0; dest_almost_full = 1'b0;
    fifo_empty = 1'b1; fifo_almost_empty = 1'b1; fifo_data = 10'd0;
    n_popped = 0; n_pushed = 0; n_xfer = 0; first_pop_cyc = -1;
    edge_ok = 1'b0; exp_push_next = 1'b0;

    //           rst   en    empty daf   data     pop   push  exp_data state
    tbl[0]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 2'd0);
    tbl[1]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 2'd0);
    tbl[2]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 2'd0);
    tbl[3]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 10'h155, 1'b0, 1'b0, 10'h000, 2'd1);
    tbl[4]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 10'h3FF, 1'b0, 1'b1, 10'h155, 2'd1);
    tbl[5]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 10'h3FF, 1'b1, 1'b0, 10'h000, 2'd0);
    tbl[6]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 10'h0A1, 1'b1, 1'b0, 10'h000, 2'd1);
    tbl[7]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 10'h0A2, 1'b0, 1'b0, 10'h000, 2'd1);
    tbl[8]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 10'h3FF, 1'b0, 1'b0, 10'h000, 2'd2);
    tbl[9]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 10'h3FF, 1'b0, 1'b0, 10'h000, 2'd2);
    tbl[10] = mk(1'b1, 1'b1, 1'b0, 1'b0, 10'h3FF, 1'b1, 1'b1, 10'h0A1, 2'd1);
    tbl[11] = mk(1'b1, 1'b1, 1'b1, 1'b0, 10'h0A3, 1'b0, 1'b1, 10'h0A2, 2'd1);
    tbl[12] = mk(1'b1, 1'b1, 1'b1, 1'b0, 10'h3FF, 1'b0, 1'b1, 10'h0A3, 2'd1);
    tbl[13] = mk(1'b1, 1'b1, 1'b1, 1'b0, 10'h3FF, 1'b0, 1'b0, 10'h000, 2'd0);

    @(posedge clk);
    #1;
    for (int i = 0; i < 14; i++) begin
      reset             = tbl[i].rst_n;
      enable            = tbl[i].en;
      fifo_empty        = tbl[i].empty;
      fifo_almost_empty = tbl[i].empty;
      dest_almost_full  = tbl[i].daf;
      fifo_data         = tbl[i].data;
      @(negedge clk);
      check($sformatf("row%0d_pop", i), 32'(fifo_pop), 32'(tbl[i].exp_pop));
      check($sformatf("row%0d_push", i), 32'(dest_push), 32'(tbl[i].exp_push));
      if (tbl[i].exp_push)
        check($sformatf("row%0d_data", i), 32'(dest_data), 32'(tbl[i].exp_data));
      check($sformatf("row%0d_state", i), 32'(state), 32'(tbl[i].exp_state));
      check($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].exp_state != 2'd0));
      @(posedge clk);
      #1;
    end

    // Eight-word stream: back-to-back pushes, two-cycle latency.
    do_reset();
    for (int i = 1; i <= 8; i++) src_q.push_back(10'(i));
    src_update();
    enable = 1'b1;
    dest_almost_full = 1'b0;
    drain(100);
    check("stream_count", 32'(n_pushed), 32'd8);
    if (push_cyc.size() == 8) begin
      check("stream_consecutive", 32'(push_cyc[7] - push_cyc[0]), 32'd7);
      check("stream_latency", 32'(push_cyc[0] - first_pop_cyc), 32'd2);
    end
`ifdef XFER_CNT_EN
    check("stream_xfer", 32'(xfer_count), 32'd8);
`endif

    // Back-pressure for five cycles mid-stream.
    do_reset();
    for (int i = 0; i < 12; i++) src_q.push_back(10'(12'h040 + i));
    src_update();
    enable = 1'b1;
    dest_almost_full = 1'b0;
    repeat (4) cycle();
    dest_almost_full = 1'b1;
    repeat (5) cycle();
    check("stall_state", 32'(state), 32'd2);
    check("stall_pop", 32'(fifo_pop), 32'd0);
    dest_almost_full = 1'b0;
    drain(100);
    check("stall_count", 32'(n_pushed), 32'd12);

    // Enable dropped after three pops.
    do_reset();
    for (int i = 0; i < 8; i++) src_q.push_back(10'(12'h080 + i));
    src_update();
    enable = 1'b1;
    for (int k = 0; k < 50 && n_popped < 3; k++) cycle();
    check("en_drop_pops", 32'(n_popped), 32'd3);
    enable = 1'b0;
    drain(50);
    check("en_drop_pushes", 32'(n_pushed), 32'd3);
    src_q.delete();
    src_update();

    // Reset with two words parked in the hold buffer.
    do_reset();
    for (int i = 0; i < 4; i++) src_q.push_back(10'(12'h2A0 + i));
    src_update();
    enable = 1'b1;
    dest_almost_full = 1'b1;
    repeat (5) cycle();
    check("prerst_state", 32'(state), 32'd2);
    do_reset();
    dest_almost_full = 1'b0;
    enable = 1'b1;
    drain(50);
    check("postrst_count", 32'(n_pushed), 32'd2);

    // 256 transfers: count reaches 255 then wraps to 0.
    do_reset();
    for (int i = 0; i < 255; i++) src_q.push_back(10'(i * 3));
    src_update();
    enable = 1'b1;
    dest_almost_full = 1'b0;
    drain(600);
    check("wrap_count255", 32'(n_pushed), 32'd255);
`ifdef XFER_CNT_EN
    check("xfer_255", 32'(xfer_count), 32'd255);
`endif
    src_q.push_back(10'h1C3);
    src_update();
    drain(20);
    check("wrap_count256", 32'(n_pushed), 32'd256);
`ifdef XFER_CNT_EN
    check("xfer_wrap", 32'(xfer_count), 32'd0);
`endif

    // Randomised traffic against the model.
    do_reset();
    for (int t = 0; t < 800; t++) begin
      if ($urandom_range(3) == 0 && src_q.size() < 8) begin
        for (int j = 0; j <= int'($urandom_range(2)); j++) src_q.push_back(10'($urandom));
      end
      src_update();
      enable = ($urandom_range(7) != 0);
      dest_almost_full = ($urandom_range(9) < 3);
      cycle();
    end
    enable = 1'b0;
    dest_almost_full = 1'b0;
    drain(50);
    check("rand_all_delivered", 32'(n_pushed), 32'(n_popped));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_drain_ctrl.md
FIFO_DRAIN_CTRL -- requirements
Module: fifo_drain_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk, reset.
REQ-002 Ports SHALL be:
clk  in  1  system clock, all state on rising edge
reset  in  1  async active-low reset
enable  in  1  permits new pops from source FIFO
fifo_empty  in  1  source FIFO holds no words (registered flag)
fifo_almost_empty  in  1  source FIFO holds <=1 word
fifo_data  in  10  source FIFO read data, valid cycle after fifo_pop
fifo_pop  out  1  pop strobe to source FIFO
dest_almost_full  in  1  downstream FIFO cannot accept further pushes
dest_push  out  1  push strobe to downstream FIFO, registered
dest_data  out  10  word accompanying dest_push, registered
busy  out  1  high whenever state != IDLE
state  out  2  FSM state: 00 IDLE, 01 RUN, 10 STALL
xfer_count  out  8  words pushed downstream (XFER_CNT_EN only)

Function
REQ-003 fifo_pop SHALL be combinational: enable & !fifo_empty & (buf_cnt + inflight) < 2.
REQ-004 inflight SHALL be a 1-bit register set to the fifo_pop value of the previous cycle.
REQ-005 When inflight=1, fifo_data SHALL be captured at the end of that cycle.
REQ-006 A captured word SHALL load the dest output register directly if the hold buffer is empty and dest_almost_full=0; otherwise it SHALL enter a 2-entry in-order hold buffer.
REQ-007 Each cycle with dest_almost_full=0 and buf_cnt>0, the buffer head SHALL load the output register with dest_push=1 next cycle; the buffer head SHALL take priority over a concurrent captured word, which then enters the buffer.
REQ-008 dest_push SHALL be 0 in any cycle following one with dest_almost_full=1, or with no word available.
REQ-009 Latency: fifo_pop high in cycle N -> dest_push high with that word in cycle N+2 when unstalled.
REQ-010 Throughput SHALL be one word per cycle while fifo_empty=0, enable=1 and dest_almost_full=0.
REQ-011 Word order SHALL be preserved; no word SHALL be dropped or duplicated.
REQ-012 buf_cnt SHALL never exceed 2; the credit rule in REQ-003 guarantees this.
REQ-013 FSM: IDLE->RUN on fifo_pop; RUN->STALL when dest_almost_full=1 and buf_cnt>0; STALL->RUN when dest_almost_full=0; RUN->IDLE when buf_cnt=0, inflight=0 and fifo_pop=0.
REQ-014 Deasserting enable SHALL stop new pops only; in-flight and buffered words SHALL still drain.
REQ-015 fifo_almost_empty SHALL be used only as a status input and SHALL NOT gate fifo_pop.

Reset
REQ-016 reset=0 SHALL asynchronously clear state to IDLE, buf_cnt, inflight, dest_push, dest_data, and xfer_count to 0.
REQ-017 fifo_pop SHALL be 0 while reset=0.
REQ-018 Reset mid-transfer SHALL discard buffered and in-flight words without a dest_push.
REQ-019 The first fifo_pop after reset release SHALL occur no earlier than the first rising edge with reset=1.

Configuration
REQ-020 With macro XFER_CNT_EN defined, xfer_count SHALL exist and increment by 1 per dest_push cycle, wrapping 255->0.
REQ-021 Without XFER_CNT_EN, xfer_count and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-022 Bench SHALL cover:
- Single word 0x155 in source, enable=1 -> one fifo_pop in cycle N, dest_push with dest_data=0x155 in N+2, then state=IDLE, busy=0.
- 8 words 0x001..0x008 streamed, dest_almost_full=0 -> 8 consecutive dest_push cycles, in order, xfer_count=8.
- dest_almost_full=1 for 5 cycles mid-stream -> fifo_pop stops with buf_cnt=2, state=STALL, no loss, order kept after release.
- enable dropped after 3 pops -> exactly 3 dest_push follow, then IDLE.
- reset asserted with 2 words buffered -> outputs 0 immediately, no dest_push, first post-reset word correct.
- 256 transfers with XFER_CNT_EN -> xfer_count wraps to 0.
